// File: rtl/dcache_data_arb_if.sv
// Requester-side handshakes and SRAM macro pins of the dcache data-array arbiter.
// The arbiter takes the slave modport; control logic and the macro sit on the master side.
interface dcache_data_arb_if #(
  parameter int ROWS   = 64,
  parameter int LINE_W = 128
);
  localparam int IDX_W  = $clog2(ROWS);
  localparam int MASK_W = LINE_W / 8;

  logic              rf_valid;
  logic              rf_ready;
  logic [IDX_W-1:0]  rf_idx;
  logic [LINE_W-1:0] rf_data;

  logic              st_valid;
  logic              st_ready;
  logic [IDX_W-1:0]  st_idx;
  logic [MASK_W-1:0] st_wmask;
  logic [LINE_W-1:0] st_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [IDX_W-1:0]  ld_idx;
  logic              ld_resp_valid;
  logic [LINE_W-1:0] ld_resp_data;

  logic              busy;

  logic              sram_csb;
  logic              sram_web;
  logic [IDX_W-1:0]  sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [LINE_W-1:0] sram_din;
  logic [LINE_W-1:0] sram_dout;

  modport slave (
    input  rf_valid, rf_idx, rf_data,
    input  st_valid, st_idx, st_wmask, st_data,
    input  ld_valid, ld_idx, sram_dout,
    output rf_ready, st_ready, ld_ready, ld_resp_valid, ld_resp_data, busy,
    output sram_csb, sram_web, sram_addr, sram_wmask, sram_din
  );

  modport master (
    output rf_valid, rf_idx, rf_data,
    output st_valid, st_idx, st_wmask, st_data,
    output ld_valid, ld_idx, sram_dout,
    input  rf_ready, st_ready, ld_ready, ld_resp_valid, ld_resp_data, busy,
    input  sram_csb, sram_web, sram_addr, sram_wmask, sram_din
  );
endinterface

// File: rtl/dcache_data_arb.sv
// Single-port dcache line SRAM arbiter: refill > store/load (round-robin when both).
// Optional post-reset zero sweep of the array is compiled in with `define DCACHE_INIT_EN.
module dcache_data_arb #(
  parameter int ROWS   = 64,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_aL,
  dcache_data_arb_if.slave  bus
);
  localparam int IDX_W = $clog2(ROWS);

  logic             w_in_init;
  logic [IDX_W-1:0] w_init_idx;
  logic             w_rf_gnt;
  logic             w_st_gnt;
  logic             w_ld_gnt;
  logic             r_last_st;
  logic             r_ld_resp_valid;

`ifdef DCACHE_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_init_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT)
        r_init_idx <= (r_init_idx == IDX_W'(ROWS - 1)) ? '0 : r_init_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_init_idx == IDX_W'(ROWS - 1))
      w_state_nxt = S_RUN;
  end

  assign w_in_init  = (r_state == S_INIT);
  assign w_init_idx = r_init_idx;
`else
  assign w_in_init  = 1'b0;
  assign w_init_idx = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_rf_gnt = 1'b0;
    w_st_gnt = 1'b0;
    w_ld_gnt = 1'b0;
    if (rst_aL && !w_in_init) begin
      if (bus.rf_valid) begin
        w_rf_gnt = 1'b1;
      end else if (bus.st_valid && bus.ld_valid) begin
        w_st_gnt = !r_last_st;
        w_ld_gnt =  r_last_st;
      end else begin
        w_st_gnt = bus.st_valid;
        w_ld_gnt = bus.ld_valid;
      end
    end
  end

  assign bus.rf_ready = w_rf_gnt;
  assign bus.st_ready = w_st_gnt;
  assign bus.ld_ready = w_ld_gnt;
  assign bus.busy     = w_in_init;

  // Pins are held at their reset values while rst_aL is low, even in INIT.
  always_comb begin
    bus.sram_csb   = 1'b1;
    bus.sram_web   = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wmask = '0;
    bus.sram_din   = '0;
    if (!rst_aL) begin
      bus.sram_web = 1'b1;
    end else if (w_in_init) begin
      bus.sram_csb   = 1'b0;
      bus.sram_addr  = w_init_idx;
      bus.sram_wmask = '1;
    end else if (w_rf_gnt) begin
      bus.sram_csb   = 1'b0;
      bus.sram_addr  = bus.rf_idx;
      bus.sram_wmask = '1;
      bus.sram_din   = bus.rf_data;
    end else if (w_st_gnt && (|bus.st_wmask)) begin
      bus.sram_csb   = 1'b0;
      bus.sram_addr  = bus.st_idx;
      bus.sram_wmask = bus.st_wmask;
      bus.sram_din   = bus.st_data;
    end else if (w_ld_gnt) begin
      bus.sram_csb  = 1'b0;
      bus.sram_web  = 1'b1;
      bus.sram_addr = bus.ld_idx;
    end
  end

  // Round-robin bit moves only when store and load actually competed.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_last_st       <= 1'b0;
      r_ld_resp_valid <= 1'b0;
    end else begin
      r_ld_resp_valid <= w_ld_gnt;
      if (w_st_gnt && bus.ld_valid)
        r_last_st <= 1'b1;
      else if (w_ld_gnt && bus.st_valid)
        r_last_st <= 1'b0;
    end
  end

  assign bus.ld_resp_valid = r_ld_resp_valid;
  assign bus.ld_resp_data  = bus.sram_dout;
endmodule
